uart_rx_deframer: RTL

- Asynchronous serial receiver: the stage directly downstream of async_transmitter, consuming its TxD line (8N1, LSB first).
- Oversamples the line, rejects start-bit glitches, recovers the byte and flags framing errors.
- Output is a one-cycle data-valid strobe for the design's RX-side logic.

---
 rtl/uart_rx_deframer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// 8N1 asynchronous receiver: synchronises and oversamples RxD, majority-filters the samples,
// rejects start-bit glitches and delivers each byte as a one-cycle strobe or a framing error.
module uart_rx_deframer #(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle
);

  localparam int unsigned TickDiv =
      (ClkFrequency + (Baud * Oversampling) / 2) / (Baud * Oversampling);
  localparam int unsigned TickW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned SampW = (Oversampling > 1) ? $clog2(Oversampling) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
  localparam logic [SampW-1:0] SampMid  = SampW'(Oversampling / 2 - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(Oversampling - 1);

  if (TickDiv < 2) begin : gBadTickDiv
    $error("uart_rx_deframer: TickDiv must be at least 2");
  end
  if (Oversampling != 8 && Oversampling != 16) begin : gBadOversampling
    $error("uart_rx_deframer: Oversampling must be 8 or 16");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } stateT;

  stateT            stateQ, stateD;
  logic             rxdMetaQ, rxdSyncQ;
  logic [2:0]       filtQ;
  logic             filtPrevQ;
  logic [TickW-1:0] tickCntQ, tickCntD;
  logic [SampW-1:0] sampleCntQ, sampleCntD;
  logic [2:0]       bitIdxQ, bitIdxD;
  logic [7:0]       shiftQ, shiftD;
  logic [7:0]       dataQ, dataD;
  logic             readyQ, readyD;
  logic             frameErrQ, frameErrD;
  logic             tick, tickClr;
  logic             filtBit, fallEdge;

  // Two-flop synchroniser: RxD is asynchronous to clk.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rxdMetaQ <= 1'b1;
      rxdSyncQ <= 1'b1;
    end else begin
      rxdMetaQ <= RxD;
      rxdSyncQ <= rxdMetaQ;
    end
  end

  assign tick = (tickCntQ == TickLast);

  always_comb begin
    tickCntD = tickCntQ + 1'b1;
    if (tickClr || tick) begin
      tickCntD = '0;
    end
  end

  assign filtBit  = (filtQ[0] & filtQ[1]) | (filtQ[0] & filtQ[2]) | (filtQ[1] & filtQ[2]);
  assign fallEdge = filtPrevQ & ~filtBit;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      tickCntQ  <= '0;
      filtQ     <= 3'b111;
      filtPrevQ <= 1'b1;
    end else begin
      tickCntQ  <= tickCntD;
      filtPrevQ <= filtBit;
      if (tick) begin
        filtQ <= {filtQ[1:0], rxdSyncQ};
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    sampleCntD = tick ? sampleCntQ + 1'b1 : sampleCntQ;
    bitIdxD    = bitIdxQ;
    shiftD     = shiftQ;
    dataD      = dataQ;
    readyD     = 1'b0;
    frameErrD  = 1'b0;
    tickClr    = 1'b0;

    unique case (stateQ)
      StIdle: begin
        // Re-phase the tick generator to the start edge so mid-bit samples line up.
        if (fallEdge) begin
          stateD     = StStart;
          sampleCntD = '0;
          tickClr    = 1'b1;
        end
      end
      StStart: begin
        if (tick && sampleCntQ == SampMid) begin
          sampleCntD = '0;
          if (!filtBit) begin
            stateD  = StData;
            bitIdxD = 3'd0;
          end else begin
            stateD = StIdle;
          end
        end
      end
      StData: begin
        if (tick && sampleCntQ == SampLast) begin
          shiftD  = {filtBit, shiftQ[7:1]};
          bitIdxD = bitIdxQ + 3'd1;
          if (bitIdxQ == 3'd7) begin
            stateD = StStop;
          end
        end
      end
      StStop: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (tick && sampleCntQ == SampLast) begin
          if (filtBit) begin
            dataD  = shiftQ;
            readyD = 1'b1;
            stateD = StIdle;
          end else begin
            frameErrD = 1'b1;
            stateD    = StBreak;
          end
        end
      end
      StBreak: begin
        if (filtBit) begin
          stateD = StIdle;
        end
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      stateQ     <= StIdle;
      sampleCntQ <= '0;
      bitIdxQ    <= 3'd0;
      shiftQ     <= 8'h00;
      dataQ      <= 8'h00;
      readyQ     <= 1'b0;
      frameErrQ  <= 1'b0;
    end else begin
      stateQ     <= stateD;
      sampleCntQ <= sampleCntD;
      bitIdxQ    <= bitIdxD;
      shiftQ     <= shiftD;
      dataQ      <= dataD;
      readyQ     <= readyD;
      frameErrQ  <= frameErrD;
    end
  end

  assign RxD_data       = dataQ;
  assign RxD_data_ready = readyQ;
  assign RxD_frame_err  = frameErrQ;
  assign RxD_idle       = (stateQ == StIdle) && filtBit;

endmodule
